// File: rtl/traffic_fsm.sv
// traffic_fsm: main/side-street light controller driving the interval timer handshake
module traffic_fsm #(
  parameter logic [3:0] T_BASE = 4'd6,
  parameter logic [3:0] T_EXT  = 4'd3,
  parameter logic [3:0] T_YEL  = 4'd2
) (
  input  logic       clk,
  input  logic       reset_sync,
  input  logic       sensor,
  input  logic       walk_req,
  input  logic       expired,
  output logic       start_t,
  output logic [3:0] tp_val,
  output logic [2:0] main_lt,
  output logic [2:0] side_lt,
  output logic       walk_lt
);
  typedef enum logic [2:0] {MG1, MG2, MY, WALK, SG, SGX, SY} state_t;
  state_t state, nxt;
  logic walk_pend, valid, adv;
  if (T_BASE == 4'd0 || T_EXT == 4'd0 || T_YEL == 4'd0) begin : g_bad_param
    $error("traffic_fsm: intervals must be 1..15");
  end
  // successor of the current state; stray encodings flag themselves invalid
  always_comb begin
    nxt = MG1;
    valid = 1'b1;
    case (state)
      MG1: nxt = sensor ? MY : MG2;
      MG2: nxt = MY;
      MY: nxt = walk_pend ? WALK : SG;
      WALK: nxt = SG;
      SG: nxt = sensor ? SGX : SY;
      SGX: nxt = SY;
      SY: nxt = MG1;
      default: valid = 1'b0;
    endcase
  end
  // the load cycle ignores expired because the timer flag is still stale then
  assign adv = !valid || (expired && !start_t);
  // state, load strobe and latched pedestrian request
  always_ff @(posedge clk or posedge reset_sync) begin
    if (reset_sync) begin
      state <= MG1;
      start_t <= 1'b1;
      walk_pend <= 1'b0;
    end else begin
      state <= adv ? nxt : state;
      start_t <= adv;
      walk_pend <= (adv && nxt == WALK) ? 1'b0 : (walk_req && state != WALK) ? 1'b1 : walk_pend;
    end
  end
  // lights and interval decode from the state register only; unknown states show all-red
  always_comb begin
    main_lt = 3'b100;
    side_lt = 3'b100;
    walk_lt = 1'b0;
    tp_val = T_BASE;
    case (state)
      MG1, MG2: main_lt = 3'b001;
      MY: begin
        main_lt = 3'b010;
        tp_val = T_YEL;
      end
      WALK: begin
        walk_lt = 1'b1;
        tp_val = T_EXT;
      end
      SG: side_lt = 3'b001;
      SGX: begin
        side_lt = 3'b001;
        tp_val = T_EXT;
      end
      SY: begin
        side_lt = 3'b010;
        tp_val = T_YEL;
      end
      default: tp_val = T_BASE;
    endcase
  end
endmodule
